counter_n_bit_modal: RTL and testbench
======================================

COUNTER_N_BIT_MODAL -- requirements
Module: counter_n_bit_modal

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the counter, data and limit width (legal range 2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, setting the reset-release synchronizer depth (legal range 2..4).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en_i  input  1  count enable.
REQ-006 SHALL have port load_i  input  1  synchronous parallel load.
REQ-007 SHALL have port data_i  input  WIDTH  load value.
REQ-008 SHALL have port up_i  input  1  direction: 1 counts up, 0 counts down.
REQ-009 SHALL have port sat_i  input  1  boundary mode: 1 saturates, 0 wraps.
REQ-010 SHALL have port max_i  input  WIDTH  runtime terminal value; the count range is 0..max_i inclusive.
REQ-011 SHALL have port ovf_clr_i  input  1  synchronous clear of ovf_o.
REQ-012 SHALL have port cnt_o  output  WIDTH  registered count value.
REQ-013 SHALL have port tc_o  output  1  registered one-cycle pulse marking a wrap event.
REQ-014 SHALL have port ovf_o  output  1  registered sticky flag marking any boundary event.

Function
REQ-015 SHALL derive an internal reset that asserts asynchronously with rst_ni low and deasserts synchronously after SYNC_STAGES rising edges of clk_i with rst_ni high; all other state uses only this internal reset.
REQ-016 SHALL apply the following per-edge priority: load_i first, then en_i; with load_i=0 and en_i=0, cnt_o holds.
REQ-017 SHALL, on load_i=1, load min(data_i, max_i) regardless of en_i, leave tc_o at 0, and leave ovf_o unchanged.
REQ-018 SHALL, with en_i=1 and up_i=1 and cnt_o<max_i, increment by 1.
REQ-019 SHALL, with en_i=1 and up_i=1 and cnt_o>=max_i: if sat_i=0, go to 0 and pulse tc_o; if sat_i=1, go to max_i with no tc_o; in both cases set ovf_o.
REQ-020 SHALL, with en_i=1 and up_i=0 and 0<cnt_o<=max_i, decrement by 1.
REQ-021 SHALL, with en_i=1 and up_i=0 and cnt_o=0: if sat_i=0, go to max_i and pulse tc_o; if sat_i=1, hold 0 with no tc_o; in both cases set ovf_o.
REQ-022 SHALL, with en_i=1 and up_i=0 and cnt_o>max_i (max_i lowered at runtime), go to max_i with no tc_o and no ovf_o change.
REQ-023 SHALL assert tc_o for exactly the one cycle following each wrap edge; consecutive wraps (for example max_i=0, sat_i=0, en_i=1) SHALL hold tc_o high continuously.
REQ-024 SHALL clear ovf_o on ovf_clr_i=1; if a set event and ovf_clr_i=1 occur on the same edge, ovf_o SHALL be 1 (set wins).
REQ-025 SHALL perform all arithmetic modulo 2^WIDTH with no carry out; max_i=2^WIDTH-1 gives full-range behaviour.
REQ-026 SHALL sample up_i, sat_i and max_i each edge; a change takes effect on the next active edge with no extra latency.

Reset
REQ-027 SHALL, while the internal reset is active, force cnt_o=0, tc_o=0 and ovf_o=0.
REQ-028 SHALL hold all outputs at reset values for SYNC_STAGES edges after rst_ni rises, ignoring en_i and load_i during that window.
REQ-029 SHALL, when rst_ni falls mid-count (including during a tc_o pulse), clear all outputs immediately without waiting for a clock edge.

Verification
REQ-030 SHALL cover reset release: WIDTH=8, SYNC_STAGES=2, en_i=1 held, rst_ni rises -> cnt_o stays 0 for 2 edges, then reads 1 after edge 3.
REQ-031 SHALL cover up-wrap: max_i=9, sat_i=0, up_i=1, load 8 -> cnt_o reads 9, then 0 with tc_o=1 for one cycle and ovf_o=1; next edge gives cnt_o=1 and tc_o=0.
REQ-032 SHALL cover down-saturate: sat_i=1, up_i=0, cnt_o=1 -> cnt_o reads 0, then holds 0 with ovf_o=1 and tc_o never asserted.
REQ-033 SHALL cover load clamp and priority: max_i=100, data_i=200, load_i=1, en_i=1 -> cnt_o=100 with tc_o=0.
REQ-034 SHALL cover runtime limit drop and clear: cnt_o=50, max_i changed to 20, up_i=0 -> cnt_o=20; then ovf_clr_i=1 on the same edge as a wrap -> ovf_o remains 1.
REQ-035 SHALL cover asynchronous mid-operation reset: rst_ni falls between edges while cnt_o=0x37 -> cnt_o=0 and ovf_o=0 before the next edge.

Source files
------------

// File: rtl/counter_n_bit_modal.sv
// Up/down counter with a runtime terminal value, selectable wrap or saturate
// at the boundaries, a wrap pulse and a sticky boundary flag.
module counter_n_bit_modal #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             ovf_o
);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_n_int;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;

  // Reset asserts immediately with rst_ni and releases only after the chain fills.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    if (load_i) begin
      cnt_d = (data_i > max_i) ? max_i : data_i;
    end else if (en_i) begin
      if (up_i) begin
        if (cnt_q < max_i) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          ovf_set = 1'b1;
          if (sat_i) begin
            cnt_d = max_i;
          end else begin
            cnt_d = '0;
            tc_d  = 1'b1;
          end
        end
      end else begin
        if (cnt_q == '0) begin
          ovf_set = 1'b1;
          if (!sat_i) begin
            cnt_d = max_i;
            tc_d  = 1'b1;
          end
        end else if (cnt_q > max_i) begin
          // Limit was lowered below the count: snap back into range quietly.
          cnt_d = max_i;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_counter_n_bit_modal.sv
// Directed bench for counter_n_bit_modal (WIDTH=8, SYNC_STAGES=2) with
// hand-computed expected values.
module tb_counter_n_bit_modal;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic       load_i;
  logic [7:0] data_i;
  logic       up_i;
  logic       sat_i;
  logic [7:0] max_i;
  logic       ovf_clr_i;
  logic [7:0] cnt_o;
  logic       tc_o;
  logic       ovf_o;

  int checkCount = 0;
  int passCount  = 0;

  counter_n_bit_modal #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .load_i    (load_i),
    .data_i    (data_i),
    .up_i      (up_i),
    .sat_i     (sat_i),
    .max_i     (max_i),
    .ovf_clr_i (ovf_clr_i),
    .cnt_o     (cnt_o),
    .tc_o      (tc_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one set of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic load, input logic [7:0] data, input logic en,
                               input logic up, input logic sat, input logic [7:0] max,
                               input logic clr);
    load_i    = load;
    data_i    = data;
    en_i      = en;
    up_i      = up;
    sat_i     = sat;
    max_i     = max;
    ovf_clr_i = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [7:0] cnt, input logic tc, input logic ovf);
    checkOutput({tag, ".cnt"}, 32'(cnt_o), 32'(cnt));
    checkOutput({tag, ".tc"},  32'(tc_o),  32'(tc));
    checkOutput({tag, ".ovf"}, 32'(ovf_o), 32'(ovf));
  endtask

  initial begin
    rst_ni = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0);
    checkAll("reset", 8'd0, 1'b0, 1'b0);

    // Release with en_i held: two edges of hold, count appears after the third
    rst_ni = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0);
    checkOutput("release.e1", 32'(cnt_o), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0);
    checkOutput("release.e2", 32'(cnt_o), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0);
    checkOutput("release.e3", 32'(cnt_o), 32'd1);

    // Up-wrap at max 9
    applyStimulus(1'b1, 8'd8, 1'b1, 1'b1, 1'b0, 8'd9, 1'b0);
    checkAll("upwrap.load", 8'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd9, 1'b0);
    checkAll("upwrap.nine", 8'd9, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd9, 1'b0);
    checkAll("upwrap.wrap", 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd9, 1'b0);
    checkAll("upwrap.after", 8'd1, 1'b0, 1'b1);

    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd9, 1'b1);
    checkAll("ovfclr", 8'd1, 1'b0, 1'b0);

    // Down-saturate from 1
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 8'd9, 1'b0);
    checkAll("downsat.load", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd9, 1'b0);
    checkAll("downsat.zero", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd9, 1'b0);
    checkAll("downsat.hold1", 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd9, 1'b0);
    checkAll("downsat.hold2", 8'd0, 1'b0, 1'b1);

    // Load clamp with en_i also high, then saturating up at the limit
    applyStimulus(1'b1, 8'd200, 1'b1, 1'b1, 1'b1, 8'd100, 1'b0);
    checkAll("clamp", 8'd100, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd100, 1'b0);
    checkAll("upsat", 8'd100, 1'b0, 1'b1);

    // Runtime limit drop, then wrap with a simultaneous clear
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd100, 1'b1);
    checkOutput("drop.clr", 32'(ovf_o), 32'd0);
    applyStimulus(1'b1, 8'd50, 1'b0, 1'b1, 1'b0, 8'd100, 1'b0);
    checkOutput("drop.load", 32'(cnt_o), 32'd50);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd20, 1'b0);
    checkAll("drop.snap", 8'd20, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd20, 1'b1);
    checkAll("setwins", 8'd0, 1'b1, 1'b1);

    // Back-to-back wraps with max 0
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    checkAll("max0.w1", 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    checkAll("max0.w2", 8'd0, 1'b1, 1'b1);

    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0);
    checkAll("downwrap", 8'd5, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0);
    checkAll("down", 8'd4, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0);
    checkAll("hold", 8'd4, 1'b0, 1'b1);

    // Full-range wrap at 255
    applyStimulus(1'b1, 8'd255, 1'b0, 1'b1, 1'b0, 8'd255, 1'b0);
    checkOutput("full.load", 32'(cnt_o), 32'd255);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0);
    checkAll("full.wrap", 8'd0, 1'b1, 1'b1);

    // Asynchronous reset between edges
    applyStimulus(1'b1, 8'h37, 1'b0, 1'b1, 1'b0, 8'd255, 1'b0);
    checkAll("async.pre", 8'h37, 1'b0, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkAll("async.post", 8'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
